// File: rtl/decode_if.sv
// Shared instruction type plus the fetch->decode and decode->rename handshake bundles.
// The sim_id field rides along with the encoding purely for debug/trace correlation.
package decode_pkg;
    typedef struct packed {
        logic [31:0] bits;
        logic [15:0] sim_id;
    } t_rv_instr;
endpackage

interface fe_de_if;
    logic                  fe_valid_de0;
    decode_pkg::t_rv_instr instr_de0;
    logic                  stall_fe;

    modport master (output fe_valid_de0, output instr_de0, input stall_fe);
    modport slave  (input fe_valid_de0, input instr_de0, output stall_fe);
endinterface

interface de_rn_if;
    logic                  de_valid_rn;
    logic                  rn_stall;
    decode_pkg::t_rv_instr instr_rn;
    logic [4:0]            rd_rn;
    logic [4:0]            rs1_rn;
    logic [4:0]            rs2_rn;
    logic [31:0]           imm_rn;
    logic                  use_imm_rn;
    logic [3:0]            alu_op_rn;
    logic                  illegal_rn;

    modport master (output de_valid_rn, input rn_stall, output instr_rn, output rd_rn,
                    output rs1_rn, output rs2_rn, output imm_rn, output use_imm_rn,
                    output alu_op_rn, output illegal_rn);
    modport slave  (input de_valid_rn, output rn_stall, input instr_rn, input rd_rn,
                    input rs1_rn, input rs2_rn, input imm_rn, input use_imm_rn,
                    input alu_op_rn, input illegal_rn);
endinterface

// File: rtl/decode.sv
// First decode stage: DEPTH-entry instruction buffer feeding a registered RV32I
// (OP / OP-IMM / LUI) decoder with valid/stall flow control to rename.
module decode #(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    flush,
    fe_de_if.slave  fe,
    de_rn_if.master rn
);
    import decode_pkg::*;

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    t_rv_instr     buf_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;

    logic          stall;
    logic          accept;
    logic          load;
    logic          pop;

    t_rv_instr     head;
    logic [31:0]   ins;
    logic [4:0]    d_rd;
    logic [4:0]    d_rs1;
    logic [4:0]    d_rs2;
    logic [31:0]   d_imm;
    logic          d_use_imm;
    logic [3:0]    d_alu;
    logic          d_ill;

    logic          de_valid_q;
    t_rv_instr     instr_q;
    logic [4:0]    rd_q;
    logic [4:0]    rs1_q;
    logic [4:0]    rs2_q;
    logic [31:0]   imm_q;
    logic          use_imm_q;
    logic [3:0]    alu_q;
    logic          ill_q;

    // stall depends only on occupancy, so rn_stall never reaches fetch combinationally
    assign stall  = (count_q == FULL) && !flush;
    assign accept = fe.fe_valid_de0 && !stall && !flush;
    assign load   = !de_valid_q || !rn.rn_stall;
    assign pop    = load && (count_q != '0) && !flush;

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_q[wr_ptr_q] <= fe.instr_de0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head = buf_q[rd_ptr_q];
    assign ins  = head.bits;

    always_comb begin
        d_rd      = '0;
        d_rs1     = '0;
        d_rs2     = '0;
        d_imm     = '0;
        d_use_imm = 1'b0;
        d_alu     = '0;
        d_ill     = 1'b1;
        case (ins[6:0])
            OPC_OP: begin
                if ((ins[31:25] == 7'b0000000) ||
                    ((ins[31:25] == 7'b0100000) && ((ins[14:12] == 3'b000) || (ins[14:12] == 3'b101)))) begin
                    d_rd  = ins[11:7];
                    d_rs1 = ins[19:15];
                    d_rs2 = ins[24:20];
                    d_alu = {ins[30], ins[14:12]};
                    d_ill = 1'b0;
                end
            end
            OPC_OPIMM: begin
                // funct3 001/101 are the shifts: 5-bit shamt, funct7 carries the SRAI select
                if (ins[13:12] == 2'b01) begin
                    if ((ins[31:25] == 7'b0000000) || ((ins[31:25] == 7'b0100000) && ins[14])) begin
                        d_rd      = ins[11:7];
                        d_rs1     = ins[19:15];
                        d_imm     = {27'b0, ins[24:20]};
                        d_use_imm = 1'b1;
                        d_alu     = {ins[30], ins[14:12]};
                        d_ill     = 1'b0;
                    end
                end else begin
                    d_rd      = ins[11:7];
                    d_rs1     = ins[19:15];
                    d_imm     = {{20{ins[31]}}, ins[31:20]};
                    d_use_imm = 1'b1;
                    d_alu     = {1'b0, ins[14:12]};
                    d_ill     = 1'b0;
                end
            end
            OPC_LUI: begin
                d_rd      = ins[11:7];
                d_imm     = {ins[31:12], 12'b0};
                d_use_imm = 1'b1;
                d_ill     = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            de_valid_q <= 1'b0;
            instr_q    <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            use_imm_q  <= 1'b0;
            alu_q      <= '0;
            ill_q      <= 1'b0;
        end else if (flush) begin
            de_valid_q <= 1'b0;
        end else if (load) begin
            de_valid_q <= (count_q != '0);
            if (count_q != '0) begin
                instr_q   <= head;
                rd_q      <= d_rd;
                rs1_q     <= d_rs1;
                rs2_q     <= d_rs2;
                imm_q     <= d_imm;
                use_imm_q <= d_use_imm;
                alu_q     <= d_alu;
                ill_q     <= d_ill;
            end
        end
    end

    assign fe.stall_fe     = stall;
    assign rn.de_valid_rn  = de_valid_q;
    assign rn.instr_rn     = instr_q;
    assign rn.rd_rn        = rd_q;
    assign rn.rs1_rn       = rs1_q;
    assign rn.rs2_rn       = rs2_q;
    assign rn.imm_rn       = imm_q;
    assign rn.use_imm_rn   = use_imm_q;
    assign rn.alu_op_rn    = alu_q;
    assign rn.illegal_rn   = ill_q;

endmodule

// File: doc/decode.md
Name: decode

Overview:
- First decode stage (de0/de1). Sits directly downstream of fetch and upstream of rename/execute.
- Accepts one t_rv_instr per cycle from fetch into a DEPTH-entry instruction buffer.
- Decodes the buffer head (RV32I OP, OP-IMM, LUI) into a registered uop.
- Hands the uop downstream with valid/stall flow control and back-pressures fetch when the buffer is full.

Parameters:
- DEPTH, 4, instruction buffer entries; power of two, >=2.

Ports:
- clk  input  1  core clock.
- reset_n  input  1  asynchronous active-low reset.
- fe_valid_de0  input  1  fetch presents a valid instruction.
- instr_de0  input  t_rv_instr  instruction from fetch; stable while stall_fe is high.
- stall_fe  output  1  decode cannot accept; fetch holds PC and its output register.
- flush  input  1  synchronous discard of all buffered and output-stage instructions.
- de_valid_rn  output  1  uop valid to rename.
- rn_stall  input  1  rename cannot accept this cycle.
- instr_rn  output  t_rv_instr  original instruction passed through unchanged, including simulation IDs.
- rd_rn  output  5  destination register.
- rs1_rn  output  5  source register 1.
- rs2_rn  output  5  source register 2; 0 when unused.
- imm_rn  output  32  immediate, extended per the rules below.
- use_imm_rn  output  1  operand B is imm_rn.
- alu_op_rn  output  4  {alt, funct3}; alt=1 only for SUB/SRA/SRAI.
- illegal_rn  output  1  unsupported or malformed encoding.

Behaviour:
- Reset (async, reset_n=0):
  - buffer empty, rd/wr pointers 0, count 0.
  - de_valid_rn=0, stall_fe=0, all other outputs 0.
  - Reset takes effect mid-operation with no handshake; in-flight instructions are lost.
- Accept:
  - accept = fe_valid_de0 & ~stall_fe; the instruction is written at wr_ptr on the edge.
  - stall_fe = (count==DEPTH) & ~flush, combinational.
  - Fetch is required to hold instr_de0 stable while stall_fe=1.
- Output stage:
  - load = ~de_valid_rn | ~rn_stall.
  - On load with count>0: the head is popped and decoded into the output registers, and de_valid_rn=1 next cycle.
  - On load with count==0: de_valid_rn=0 next cycle.
  - While de_valid_rn & rn_stall: all *_rn outputs are held bit-stable.
- Latency:
  - Instruction accepted at edge E0 appears on *_rn after edge E1, i.e. 2 cycles minimum.
  - There is no bypass around the buffer.
- Simultaneous push and pop: count unchanged, so full-with-pop still stalls.
  - This is intentional: stall_fe depends only on count, with no combinational path from rn_stall.
- Pointers: log2(DEPTH) bits, wrap naturally. count is log2(DEPTH)+1 bits.
- Flush:
  - On the edge: pointers=0, count=0, de_valid_rn=0.
  - Any instruction accepted in the flush cycle is dropped.
  - stall_fe is forced 0 during flush.
  - flush overrides push, pop and load.
- Decode, applied to the 32-bit RISC-V encoding in t_rv_instr:
  - OP (0110011):
    - rd/rs1/rs2 from fields; use_imm=0; alt=funct7[5].
    - Legal iff funct7==0000000, or funct7==0100000 with funct3 in {000,101}.
  - OP-IMM (0010011):
    - rs2=0; use_imm=1.
    - funct3 in {001,101}: imm = zero-extended instr[24:20]; alt=instr[30].
      - Legal iff instr[31:25]==0000000, or ==0100000 with funct3=101.
    - Otherwise: imm = sign-extended instr[31:20]; alt=0.
  - LUI (0110111): rs1=0, rs2=0, imm={instr[31:12],12'b0}, use_imm=1, alu_op=0000 (ADD).
  - Any other opcode, or a malformed field as above:
    - illegal_rn=1, rd_rn=0, use_imm=0, alu_op=0.
    - The instruction still flows downstream in order.
- Ordering: strict FIFO; no reordering or drops except on flush.

Test Plan:
- Single ADDI x1,x1,0x123 (0x12308093) into empty decode → de_valid_rn=1 two cycles later with rd=1, rs1=1, imm=0x00000123, use_imm=1, alu_op=0000, illegal=0, for exactly one cycle.
- SUB x16,x17,x1 (0x40188833), XORI x18,x16,0xfff (0xFFF84913), SRAI x20,x18,1 (0x40195A13) back-to-back → in-order uops:
  - alu_op 1000, rs2=1.
  - alu_op 0100, imm=0xFFFFFFFF.
  - alu_op 1101, imm=0x00000001.
- rn_stall held high for 10 cycles under continuous fetch → stall_fe rises once count=4.
  - *_rn bit-stable throughout.
  - On release, all 5 instructions (1 output + 4 buffered) emerge in order with no duplicates.
- Encoding 0x0000006F (JAL) and OP with funct7=0000001 → illegal_rn=1, rd_rn=0, order preserved.
- flush asserted with buffer full and rn_stall=1 → next cycle de_valid_rn=0, count=0, stall_fe=0.
  - The instruction presented during the flush cycle never appears.
- reset_n pulsed low mid-stream, asynchronously between edges → outputs 0 immediately.
  - After release, the first post-reset instruction decodes correctly with 2-cycle latency.
